// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/LSU unified memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned MaskW     = 4;
    localparam logic [MaskW-1:0] FULL_MASK = 4'hF;

    typedef enum logic {
        OWN_IF,
        OWN_LSU
    } owner_e;

    typedef enum logic [1:0] {
        IDLE,
        IF_WAIT,
        LSU_WAIT,
        RESP
    } arb_state_e;

    // Round-robin pick: on a tie the requester that did not own the port last wins.
    function automatic owner_e pick_owner(input logic if_req, input logic lsu_req,
                                          input owner_e last_owner);
        if (if_req && lsu_req) begin
            return (last_owner == OWN_LSU) ? OWN_IF : OWN_LSU;
        end
        return if_req ? OWN_IF : OWN_LSU;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, response and memory-side signals of the unified memory port.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned DataWidth = 32
);
    logic                 if_req;
    logic [DataWidth-1:0] if_addr;
    logic                 if_gnt;
    logic                 if_valid;
    logic [DataWidth-1:0] if_rdata;

    logic                 lsu_req;
    logic                 lsu_we;
    logic [MaskW-1:0]     lsu_mask;
    logic [DataWidth-1:0] lsu_addr;
    logic [DataWidth-1:0] lsu_wdata;
    logic                 lsu_gnt;
    logic                 lsu_valid;
    logic [DataWidth-1:0] lsu_rdata;

    logic                 mem_request;
    logic                 mem_we_re;
    logic [MaskW-1:0]     mem_mask;
    logic [DataWidth-1:0] mem_addr;
    logic [DataWidth-1:0] mem_wdata;
    logic [DataWidth-1:0] mem_rdata;
    logic                 mem_valid;

    logic                 bus_err;
    logic                 busy;

    modport master (
        output if_req, if_addr, lsu_req, lsu_we, lsu_mask, lsu_addr, lsu_wdata,
               mem_rdata, mem_valid,
        input  if_gnt, if_valid, if_rdata, lsu_gnt, lsu_valid, lsu_rdata,
               mem_request, mem_we_re, mem_mask, mem_addr, mem_wdata, bus_err, busy
    );

    modport slave (
        input  if_req, if_addr, lsu_req, lsu_we, lsu_mask, lsu_addr, lsu_wdata,
               mem_rdata, mem_valid,
        output if_gnt, if_valid, if_rdata, lsu_gnt, lsu_valid, lsu_rdata,
               mem_request, mem_we_re, mem_mask, mem_addr, mem_wdata, bus_err, busy
    );

endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Wait-cycle counter; o_expired_c flags the last permitted wait cycle.
module mem_watchdog #(
    parameter int unsigned Timeout = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);
    localparam int unsigned CntW = $clog2(Timeout + 1);

    logic [CntW-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired_c) begin
            r_count <= r_count + CntW'(1);
        end
    end

    // Counter is 0 on the first wait cycle, so Timeout-1 marks the Timeout-th cycle.
    assign o_expired_c = i_enable && (r_count == CntW'(Timeout - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and LSU onto one memory port, holds the transaction until
// data_valid or watchdog abort, and returns the response to its issuer.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Timeout   = 64
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    arb_state_e           r_state, w_state_n;
    owner_e               r_last_owner, w_last_owner_n, w_sel;
    logic                 r_mem_request, w_mem_request_n;
    logic                 r_mem_we, w_mem_we_n;
    logic [MaskW-1:0]     r_mem_mask, w_mem_mask_n;
    logic [DataWidth-1:0] r_mem_addr, w_mem_addr_n;
    logic [DataWidth-1:0] r_mem_wdata, w_mem_wdata_n;
    logic                 r_if_valid, w_if_valid_n;
    logic                 r_lsu_valid, w_lsu_valid_n;
    logic                 r_bus_err, w_bus_err_n;
    logic [DataWidth-1:0] r_if_rdata, w_if_rdata_n;
    logic [DataWidth-1:0] r_lsu_rdata, w_lsu_rdata_n;
    logic [DataWidth-1:0] w_rdata;
    logic                 w_if_gnt, w_lsu_gnt, w_in_wait, w_expired;

    assign w_in_wait = (r_state == IF_WAIT) || (r_state == LSU_WAIT);

    mem_watchdog #(.Timeout(Timeout)) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (!w_in_wait),
        .i_enable   (w_in_wait),
        .o_expired_c(w_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_last_owner  <= OWN_LSU;
            r_mem_request <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_mask    <= '0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_if_valid    <= 1'b0;
            r_lsu_valid   <= 1'b0;
            r_bus_err     <= 1'b0;
            r_if_rdata    <= '0;
            r_lsu_rdata   <= '0;
        end else begin
            r_state       <= w_state_n;
            r_last_owner  <= w_last_owner_n;
            r_mem_request <= w_mem_request_n;
            r_mem_we      <= w_mem_we_n;
            r_mem_mask    <= w_mem_mask_n;
            r_mem_addr    <= w_mem_addr_n;
            r_mem_wdata   <= w_mem_wdata_n;
            r_if_valid    <= w_if_valid_n;
            r_lsu_valid   <= w_lsu_valid_n;
            r_bus_err     <= w_bus_err_n;
            r_if_rdata    <= w_if_rdata_n;
            r_lsu_rdata   <= w_lsu_rdata_n;
        end
    end

    always_comb begin
        w_state_n       = r_state;
        w_last_owner_n  = r_last_owner;
        w_mem_request_n = r_mem_request;
        w_mem_we_n      = r_mem_we;
        w_mem_mask_n    = r_mem_mask;
        w_mem_addr_n    = r_mem_addr;
        w_mem_wdata_n   = r_mem_wdata;
        w_if_valid_n    = 1'b0;
        w_lsu_valid_n   = 1'b0;
        w_bus_err_n     = 1'b0;
        w_if_rdata_n    = r_if_rdata;
        w_lsu_rdata_n   = r_lsu_rdata;
        w_if_gnt        = 1'b0;
        w_lsu_gnt       = 1'b0;
        w_rdata         = '0;
        w_sel           = pick_owner(bus.if_req, bus.lsu_req, r_last_owner);

        case (r_state)
            IDLE: begin
                if (bus.if_req || bus.lsu_req) begin
                    w_last_owner_n  = w_sel;
                    w_mem_request_n = 1'b1;
                    if (w_sel == OWN_IF) begin
                        w_if_gnt      = 1'b1;
                        w_mem_we_n    = 1'b0;
                        w_mem_mask_n  = FULL_MASK;
                        w_mem_addr_n  = bus.if_addr;
                        w_mem_wdata_n = '0;
                        w_state_n     = IF_WAIT;
                    end else begin
                        w_lsu_gnt     = 1'b1;
                        w_mem_we_n    = bus.lsu_we;
                        w_mem_mask_n  = bus.lsu_mask;
                        w_mem_addr_n  = bus.lsu_addr;
                        w_mem_wdata_n = bus.lsu_wdata;
                        w_state_n     = LSU_WAIT;
                    end
                end
            end
            IF_WAIT, LSU_WAIT: begin
                // A response in the expiry cycle still counts as a normal completion.
                if (bus.mem_valid || w_expired) begin
                    w_rdata         = (bus.mem_valid && !r_mem_we) ? bus.mem_rdata : '0;
                    w_bus_err_n     = !bus.mem_valid;
                    w_mem_request_n = 1'b0;
                    w_mem_we_n      = 1'b0;
                    w_mem_mask_n    = '0;
                    w_mem_addr_n    = '0;
                    w_mem_wdata_n   = '0;
                    w_state_n       = RESP;
                    if (r_state == IF_WAIT) begin
                        w_if_valid_n = 1'b1;
                        w_if_rdata_n = w_rdata;
                    end else begin
                        w_lsu_valid_n = 1'b1;
                        w_lsu_rdata_n = w_rdata;
                    end
                end
            end
            RESP:    w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    // Grants are combinational, so mask them while reset is held.
    assign bus.if_gnt      = rst && w_if_gnt;
    assign bus.lsu_gnt     = rst && w_lsu_gnt;
    assign bus.if_valid    = r_if_valid;
    assign bus.if_rdata    = r_if_rdata;
    assign bus.lsu_valid   = r_lsu_valid;
    assign bus.lsu_rdata   = r_lsu_rdata;
    assign bus.mem_request = r_mem_request;
    assign bus.mem_we_re   = r_mem_we;
    assign bus.mem_mask    = r_mem_mask;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.bus_err     = r_bus_err;
    assign bus.busy        = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: load, store, timeout, collision, reset, round-robin.
module tb_mem_port_arbiter;

    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errs   = 0;

    mem_port_arbiter_if #(.DataWidth(DW)) bus ();

    mem_port_arbiter #(.DataWidth(DW), .Timeout(4)) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.lsu_req   = 1'b0;
        bus.lsu_we    = 1'b0;
        bus.lsu_mask  = 4'hF;
        bus.lsu_addr  = '0;
        bus.lsu_wdata = '0;
        bus.mem_rdata = '0;
        bus.mem_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        #2;
        chk("rst_mem_request", DW'(bus.mem_request), 0);
        chk("rst_busy",        DW'(bus.busy),        0);
        chk("rst_bus_err",     DW'(bus.bus_err),     0);
        chk("rst_mem_mask",    DW'(bus.mem_mask),    0);
        step();
        rst = 1'b1;
        step();

        // Single load, response after three wait cycles
        step(); bus.lsu_req = 1'b1; bus.lsu_addr = 32'h100; #1;
        chk("ld_lsu_gnt", DW'(bus.lsu_gnt), 1);
        chk("ld_if_gnt",  DW'(bus.if_gnt),  0);
        step(); bus.lsu_req = 1'b0; #1;
        chk("ld_req_c1",  DW'(bus.mem_request), 1);
        chk("ld_addr",    bus.mem_addr, 32'h100);
        chk("ld_we",      DW'(bus.mem_we_re), 0);
        chk("ld_busy",    DW'(bus.busy), 1);
        step(); #1;
        chk("ld_req_c2",  DW'(bus.mem_request), 1);
        step(); bus.mem_valid = 1'b1; bus.mem_rdata = 32'hDEADBEEF; #1;
        chk("ld_req_c3",  DW'(bus.mem_request), 1);
        step(); bus.mem_valid = 1'b0; #1;
        chk("ld_lsu_valid", DW'(bus.lsu_valid), 1);
        chk("ld_lsu_rdata", bus.lsu_rdata, 32'hDEADBEEF);
        chk("ld_if_valid",  DW'(bus.if_valid), 0);
        chk("ld_req_c4",    DW'(bus.mem_request), 0);
        step(); #1;
        chk("ld_valid_drop", DW'(bus.lsu_valid), 0);
        chk("ld_idle",       DW'(bus.busy), 0);

        // Store: payload held until mem_valid, read data forced to zero
        step();
        bus.lsu_req = 1'b1; bus.lsu_we = 1'b1; bus.lsu_mask = 4'b0011;
        bus.lsu_wdata = 32'h1234ABCD; bus.lsu_addr = 32'h204; #1;
        chk("st_lsu_gnt", DW'(bus.lsu_gnt), 1);
        step(); idle_inputs(); #1;
        chk("st_we",    DW'(bus.mem_we_re), 1);
        chk("st_mask",  DW'(bus.mem_mask), 32'h3);
        chk("st_wdata", bus.mem_wdata, 32'h1234ABCD);
        chk("st_addr",  bus.mem_addr, 32'h204);
        step(); bus.mem_valid = 1'b1; bus.mem_rdata = 32'hFFFFFFFF; #1;
        chk("st_wdata_hold", bus.mem_wdata, 32'h1234ABCD);
        chk("st_we_hold",    DW'(bus.mem_we_re), 1);
        step(); bus.mem_valid = 1'b0; #1;
        chk("st_lsu_valid", DW'(bus.lsu_valid), 1);
        chk("st_lsu_rdata", bus.lsu_rdata, 0);
        chk("st_we_clear",  DW'(bus.mem_we_re), 0);
        chk("st_wd_clear",  bus.mem_wdata, 0);
        step(); #1;

        // Fetch timeout: four wait cycles, then abort
        step(); bus.if_req = 1'b1; bus.if_addr = 32'h40; #1;
        chk("to_if_gnt", DW'(bus.if_gnt), 1);
        for (int i = 1; i <= 4; i++) begin
            step(); bus.if_req = 1'b0; #1;
            chk("to_req_high", DW'(bus.mem_request), 1);
            if (i == 1) begin
                chk("to_addr", bus.mem_addr, 32'h40);
                chk("to_mask", DW'(bus.mem_mask), 32'hF);
            end
        end
        step(); #1;
        chk("to_req_low",  DW'(bus.mem_request), 0);
        chk("to_if_valid", DW'(bus.if_valid), 1);
        chk("to_bus_err",  DW'(bus.bus_err), 1);
        chk("to_if_rdata", bus.if_rdata, 0);
        step(); bus.mem_valid = 1'b1; bus.mem_rdata = 32'h55; #1;
        chk("to_err_drop", DW'(bus.bus_err), 0);
        chk("to_idle",     DW'(bus.busy), 0);
        step(); bus.mem_valid = 1'b0; #1;
        chk("late_if_valid",  DW'(bus.if_valid), 0);
        chk("late_lsu_valid", DW'(bus.lsu_valid), 0);
        chk("late_busy",      DW'(bus.busy), 0);
        chk("late_mem_req",   DW'(bus.mem_request), 0);

        // Response in the same cycle the watchdog expires
        step(); bus.if_req = 1'b1; bus.if_addr = 32'h80; #1;
        chk("ec_if_gnt", DW'(bus.if_gnt), 1);
        for (int i = 1; i <= 3; i++) begin
            step(); bus.if_req = 1'b0; #1;
            chk("ec_req_high", DW'(bus.mem_request), 1);
        end
        step(); bus.mem_valid = 1'b1; bus.mem_rdata = 32'hCAFEF00D; #1;
        chk("ec_req_c4", DW'(bus.mem_request), 1);
        step(); bus.mem_valid = 1'b0; #1;
        chk("ec_if_valid", DW'(bus.if_valid), 1);
        chk("ec_if_rdata", bus.if_rdata, 32'hCAFEF00D);
        chk("ec_bus_err",  DW'(bus.bus_err), 0);
        step(); #1;
        chk("ec_bus_err2", DW'(bus.bus_err), 0);

        // Asynchronous reset while an LSU transaction is outstanding
        step(); bus.lsu_req = 1'b1; bus.lsu_addr = 32'h500; #1;
        chk("rs_lsu_gnt", DW'(bus.lsu_gnt), 1);
        step(); bus.lsu_req = 1'b0; #1;
        chk("rs_busy_pre", DW'(bus.busy), 1);
        rst = 1'b0; bus.if_req = 1'b1; bus.lsu_req = 1'b1; #1;
        chk("rs_mem_req", DW'(bus.mem_request), 0);
        chk("rs_busy",    DW'(bus.busy), 0);
        chk("rs_addr",    bus.mem_addr, 0);
        chk("rs_if_gnt",  DW'(bus.if_gnt), 0);
        chk("rs_lsu_gnt_held", DW'(bus.lsu_gnt), 0);

        // Release with both requesters held and memory always ready
        step();
        rst = 1'b1;
        bus.if_addr = 32'h300; bus.lsu_addr = 32'h400; bus.lsu_we = 1'b0;
        bus.mem_valid = 1'b1; bus.mem_rdata = 32'h600DF00D; #1;
        for (int k = 0; k < 12; k++) begin
            chk("rr_if_gnt",  DW'(bus.if_gnt),  DW'(k % 6 == 0));
            chk("rr_lsu_gnt", DW'(bus.lsu_gnt), DW'(k % 6 == 3));
            chk("rr_if_valid",  DW'(bus.if_valid),  DW'(k % 6 == 2));
            chk("rr_lsu_valid", DW'(bus.lsu_valid), DW'(k % 6 == 5));
            if (k % 6 == 1) chk("rr_if_addr",  bus.mem_addr, 32'h300);
            if (k % 6 == 4) chk("rr_lsu_addr", bus.mem_addr, 32'h400);
            if (k % 6 == 5) chk("rr_lsu_rdata", bus.lsu_rdata, 32'h600DF00D);
            step(); #1;
        end

        idle_inputs();
        step(); step(); #1;
        chk("end_busy", DW'(bus.busy), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
